logic_op_arbiter: RTL and testbench

//  Shares one registered bitwise logic unit among N requesters. The unit supports
//  NOT/AND/NAND/OR/NOR/XOR/XNOR. Arbitration is round-robin. Each operation runs through
//  a 3-state sequencer and returns its result tagged with the requester id. It sits

---
 rtl/logic_op_arbiter.sv | 140 ++++++++++++++
 tb/tb_logic_op_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter that shares one registered bitwise logic unit among N requesters.
// Each operation walks IDLE -> EXEC -> RESP and returns a result tagged with its requester id.
module logic_op_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [3*N-1:0]     op,
  input  logic [WIDTH*N-1:0] a,
  input  logic [WIDTH*N-1:0] b,
  output logic [N-1:0]       gnt,
  output logic               busy,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [WIDTH-1:0]   res,
  output logic               res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               vld_q, vld_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [IDW-1:0]     win;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] opc,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (opc)
      3'd0:    logic_fn = ~x;
      3'd1:    logic_fn = x & y;
      3'd2:    logic_fn = ~(x & y);
      3'd3:    logic_fn = x | y;
      3'd4:    logic_fn = ~(x | y);
      3'd5:    logic_fn = x ^ y;
      3'd6:    logic_fn = ~(x ^ y);
      default: logic_fn = '0;
    endcase
  endfunction

  // Winner is the first active request at or after rr_q, wrapping modulo N.
  always_comb begin : win_search
    int  j;
    logic hit;
    j   = 0;
    hit = 1'b0;
    win = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (!hit && req[j]) begin
        win = IDW'(j);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = '0;
    vld_d    = 1'b0;
    res_id_d = res_id_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          op_d       = op[3*win +: 3];
          a_d        = a[WIDTH*win +: WIDTH];
          b_d        = b[WIDTH*win +: WIDTH];
          id_d       = win;
          gnt_d[win] = 1'b1;
          rr_d       = (win == IDW'(N-1)) ? '0 : win + 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d    = logic_fn(op_q, a_q, b_q);
        res_id_d = id_q;
        err_d    = (op_q == 3'd7);
        vld_d    = 1'b1;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      res_id_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      res_id_q <= res_id_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = vld_q;
  assign res_id    = res_id_q;
  assign res       = res_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed and randomized bench for logic_op_arbiter against a behavioural arbitration/ALU model.
module tb_logic_op_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef logic [N-1:0]   req_t;
  typedef logic [3*N-1:0] op_t;
  typedef logic [W*N-1:0] dat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  req_t         req = '0;
  op_t          op  = '0;
  dat_t         a   = '0;
  dat_t         b   = '0;
  logic [N-1:0] gnt;
  logic         busy, res_valid, res_err;
  logic [1:0]   res_id;
  logic [W-1:0] res;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           rr_m    = 0;
  logic [W-1:0] last_res;
  int           last_id;
  logic [W-1:0] sweep_tbl [8];
  int           seq_tbl [5];

  logic_op_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res(res), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] model_fn(input int opc, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    case (opc)
      0: return ~x;
      1: return x & y;
      2: return ~(x & y);
      3: return x | y;
      4: return ~(x | y);
      5: return x ^ y;
      6: return ~(x ^ y);
      default: return '0;
    endcase
  endfunction

  function automatic int pick(input req_t rq, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (rq[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // mode 0: hold inputs; 1: scramble inputs and drop winner req in gnt cycle; 2: a0 <= FF in gnt cycle
  task automatic run_op(input string tag, input int mode);
    int           w;
    int           oc;
    logic [W-1:0] er;
    w    = pick(req, rr_m);
    oc   = int'(op[3*w +: 3]);
    er   = model_fn(oc, a[W*w +: W], b[W*w +: W]);
    rr_m = (w + 1) % N;
    step();
    chk({tag, ".gnt"}, 64'(gnt), 64'(1) << w);
    chk({tag, ".busy_exec"}, 64'(busy), 64'd1);
    chk({tag, ".vld_exec"}, 64'(res_valid), 64'd0);
    if (mode == 1) begin
      op     = op_t'($urandom);
      a      = dat_t'($urandom);
      b      = dat_t'($urandom);
      req[w] = 1'b0;
    end else if (mode == 2) begin
      a[W-1:0] = 8'hFF;
    end
    step();
    chk({tag, ".vld_resp"}, 64'(res_valid), 64'd1);
    chk({tag, ".res"}, 64'(res), 64'(er));
    chk({tag, ".res_id"}, 64'(res_id), 64'(w));
    chk({tag, ".res_err"}, 64'(res_err), 64'(oc == 7));
    chk({tag, ".gnt_resp"}, 64'(gnt), 64'd0);
    last_res = res;
    last_id  = int'(res_id);
    step();
    chk({tag, ".vld_idle"}, 64'(res_valid), 64'd0);
    chk({tag, ".busy_idle"}, 64'(busy), 64'd0);
    chk({tag, ".gnt_idle"}, 64'(gnt), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst  = 1'b0;
    rr_m = 0;
  endtask

  initial begin
    sweep_tbl = '{8'h5A, 8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h00};
    seq_tbl   = '{0, 1, 2, 3, 0};

    // Reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle.gnt", 64'(gnt), 64'd0);
      chk("idle.busy", 64'(busy), 64'd0);
      chk("idle.vld", 64'(res_valid), 64'd0);
      chk("idle.res", 64'(res), 64'd0);
      chk("idle.res_id", 64'(res_id), 64'd0);
      chk("idle.res_err", 64'(res_err), 64'd0);
    end

    // Single AND request
    req = 4'b0001; op[2:0] = 3'd1; a[7:0] = 8'hF0; b[7:0] = 8'h3C;
    run_op("and", 0);
    chk("and.const", 64'(last_res), 64'h30);

    // Continuous full request: round-robin order
    do_reset();
    req = 4'b1111;
    op  = {3'd5, 3'd3, 3'd1, 3'd0};
    a   = dat_t'($urandom);
    b   = dat_t'($urandom);
    for (int i = 0; i < 5; i++) begin
      run_op("rr", 0);
      chk("rr.seq", 64'(last_id), 64'(seq_tbl[i]));
    end

    // Opcode sweep on requester 2
    req = 4'b0100; a[23:16] = 8'hA5; b[23:16] = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      op[8:6] = 3'(k);
      run_op("sweep", 0);
      chk("sweep.const", 64'(last_res), 64'(sweep_tbl[k]));
    end

    // Operand change during grant cycle
    req = 4'b0001; op[2:0] = 3'd3; a[7:0] = 8'h0F; b[7:0] = 8'h00;
    run_op("late_a", 2);
    chk("late_a.const", 64'(last_res), 64'h0F);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        step();
        chk("rnd.idle_gnt", 64'(gnt), 64'd0);
        chk("rnd.idle_busy", 64'(busy), 64'd0);
        chk("rnd.idle_vld", 64'(res_valid), 64'd0);
      end else begin
        req = req_t'($urandom_range(1, (1 << N) - 1));
        op  = op_t'($urandom);
        a   = dat_t'($urandom);
        b   = dat_t'($urandom);
        run_op("rnd", 1);
      end
    end

    // Reset during EXEC
    req = 4'b0010; op = '0;
    run_op("pre_rst", 0);
    req = 4'b1010;
    step();
    chk("mid.gnt", 64'(gnt), 64'b1000);
    rst = 1'b1;
    #1;
    chk("mid.gnt_clr", 64'(gnt), 64'd0);
    chk("mid.busy_clr", 64'(busy), 64'd0);
    step();
    chk("mid.no_vld", 64'(res_valid), 64'd0);
    step();
    chk("mid.no_vld2", 64'(res_valid), 64'd0);
    rst  = 1'b0;
    rr_m = 0;
    run_op("post_rst", 0);
    chk("post_rst.id", 64'(last_id), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
